// File: rtl/mult_ctrl_pkg.sv
// Shared encodings for the shift-and-add multiplier controller and its bench.
package mult_ctrl_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [2:0] CNT_LAST = 3'd7;

endpackage

// File: rtl/full_adder_8bits.sv
// 8-bit ripple-carry adder; the single shared datapath adder of the multiplier.
module full_adder_8bits (
    input  logic [7:0] n_1,
    input  logic [7:0] n_2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic carry;

    // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = n_1[i] ^ n_2[i] ^ carry;
            carry  = (n_1[i] & n_2[i]) | (carry & (n_1[i] ^ n_2[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 8x8 unsigned multiplier: one adder reused over eight shift-and-add cycles,
// with valid/ready handshakes on operands and product.
module shift_add_mult_ctrl
    import mult_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] acc_hi_q, acc_hi_d;
    logic [7:0] acc_lo_q, acc_lo_d;

    logic [7:0] add_n2;
    logic [7:0] add_sum;
    logic       add_cout;

    assign add_n2 = acc_lo_q[0] ? mcand_q : 8'h00;

    full_adder_8bits u_adder (
        .n_1  (acc_hi_q),
        .n_2  (add_n2),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = 8'h00;
                    acc_lo_d = b;
                    cnt_d    = 3'd0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // The adder carry-out becomes the top bit, so the shift never loses product bits.
                {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            mcand_q  <= 8'h00;
            acc_hi_q <= 8'h00;
            acc_lo_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule
